// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel gradient engine.
//   SOBEL_LAT     : register stages between input acceptance and the output
//   SOBEL_MAX_W   : internal width of the stage record gradient fields;
//                   supports PIX_W up to 13
//   P0..P8        : window pixel indices, row-major, P0 = top-left
//   sobel_stage_t : stage record {valid, gx, gy}
//   sobel_abs     : absolute value of a stage-record gradient
package sobel_pkg;

    localparam int SOBEL_LAT   = 3;
    localparam int SOBEL_MAX_W = 16;

    localparam int P0 = 0;
    localparam int P1 = 1;
    localparam int P2 = 2;
    localparam int P3 = 3;
    localparam int P4 = 4;
    localparam int P5 = 5;
    localparam int P6 = 6;
    localparam int P7 = 7;
    localparam int P8 = 8;

    typedef struct packed {
        logic                          valid;
        logic signed [SOBEL_MAX_W-1:0] gx;
        logic signed [SOBEL_MAX_W-1:0] gy;
    } sobel_stage_t;

    // Gradients never reach the most negative value, so the negation cannot wrap.
    function automatic logic [SOBEL_MAX_W-1:0] sobel_abs(input logic signed [SOBEL_MAX_W-1:0] v);
        return v[SOBEL_MAX_W-1] ? -v : v;
    endfunction

endpackage

// File: rtl/sobel_kernel_sum.sv
// 1-2-1 weighted sum a + 2b + c of three unsigned pixels (combinational).
//   a_i, b_i, c_i : unsigned pixels, PIX_W bits
//   sum_o         : unsigned sum, PIX_W+2 bits (the result cannot overflow)
module sobel_kernel_sum #(
    parameter int PIX_W = 8
) (
    input  logic [PIX_W-1:0] a_i,
    input  logic [PIX_W-1:0] b_i,
    input  logic [PIX_W-1:0] c_i,
    output logic [PIX_W+1:0] sum_o
);

    assign sum_o = {2'b00, a_i} + {1'b0, b_i, 1'b0} + {2'b00, c_i};

endmodule

// File: rtl/sobel_gradient_engine.sv
// Three-stage pipelined 3x3 Sobel operator with valid/ready on both sides.
//   S1: four 1-2-1 partial sums.  S2: Gx/Gy differences.
//   S3: |Gx|+|Gy|, threshold compare; S3 is the output register.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   enable                         1 = accept new windows
//   in_valid/in_ready/in_pixels    window input, p0 at MSB .. p8 at LSB
//   threshold                      edge threshold, sampled when S3 loads
//   out_valid/out_ready            result handshake
//   out_gx, out_gy (signed), out_mag, out_edge   result
//   busy                           any stage holds valid data
//   count_clear, edge_count        saturating count of delivered edge results
module sobel_gradient_engine
    import sobel_pkg::*;
#(
    parameter  int PIX_W  = 8,
    parameter  int CNT_W  = 16,
    localparam int GRAD_W = PIX_W + 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [9*PIX_W-1:0]       in_pixels,
    input  logic [GRAD_W-1:0]        threshold,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [GRAD_W-1:0] out_gx,
    output logic signed [GRAD_W-1:0] out_gy,
    output logic [GRAD_W-1:0]        out_mag,
    output logic                     out_edge,
    output logic                     busy,
    input  logic                     count_clear,
    output logic [CNT_W-1:0]         edge_count
);

    // Unpack the window so the kernel taps read as named pixel indices.
    logic [PIX_W-1:0] pix [9];
    for (genvar gi = 0; gi < 9; gi++) begin : g_unpack
        assign pix[gi] = in_pixels[(8-gi)*PIX_W +: PIX_W];
    end

    logic [PIX_W+1:0] gx_pos_d, gx_neg_d, gy_pos_d, gy_neg_d;

    sobel_kernel_sum #(.PIX_W(PIX_W)) u_gx_pos (
        .a_i(pix[P2]), .b_i(pix[P5]), .c_i(pix[P8]), .sum_o(gx_pos_d));
    sobel_kernel_sum #(.PIX_W(PIX_W)) u_gx_neg (
        .a_i(pix[P0]), .b_i(pix[P3]), .c_i(pix[P6]), .sum_o(gx_neg_d));
    sobel_kernel_sum #(.PIX_W(PIX_W)) u_gy_pos (
        .a_i(pix[P6]), .b_i(pix[P7]), .c_i(pix[P8]), .sum_o(gy_pos_d));
    sobel_kernel_sum #(.PIX_W(PIX_W)) u_gy_neg (
        .a_i(pix[P0]), .b_i(pix[P1]), .c_i(pix[P2]), .sum_o(gy_neg_d));

    // Pipeline state
    logic                     s1_valid_q;
    logic [PIX_W+1:0]         gx_pos_q, gx_neg_q, gy_pos_q, gy_neg_q;
    sobel_stage_t             s2_q, s2_d;
    logic                     out_valid_q;
    logic signed [GRAD_W-1:0] out_gx_q, out_gy_q;
    logic [GRAD_W-1:0]        out_mag_q, mag_d;
    logic                     out_edge_q;
    logic [CNT_W-1:0]         edge_count_q;

    // The whole pipeline moves as one unit: it only holds when the output
    // register is full and not being taken, so no bubble is ever squeezed.
    logic advance, accept;
    assign advance  = !out_valid_q || out_ready;
    assign in_ready = enable && advance && !rst;
    assign accept   = in_valid && in_ready;

    logic signed [GRAD_W-1:0] gx_diff, gy_diff;
    assign gx_diff = $signed({1'b0, gx_pos_q}) - $signed({1'b0, gx_neg_q});
    assign gy_diff = $signed({1'b0, gy_pos_q}) - $signed({1'b0, gy_neg_q});

    always_comb begin
        s2_d       = s2_q;
        s2_d.valid = s1_valid_q;
        if (s1_valid_q) begin
            s2_d.gx = SOBEL_MAX_W'(gx_diff);
            s2_d.gy = SOBEL_MAX_W'(gy_diff);
        end
    end

    // |Gx|+|Gy| is bounded by 8*(2^PIX_W-1), so it always fits in GRAD_W.
    assign mag_d = GRAD_W'(sobel_abs(s2_q.gx) + sobel_abs(s2_q.gy));

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            gx_pos_q    <= '0;
            gx_neg_q    <= '0;
            gy_pos_q    <= '0;
            gy_neg_q    <= '0;
            s2_q        <= '0;
            out_valid_q <= 1'b0;
            out_gx_q    <= '0;
            out_gy_q    <= '0;
            out_mag_q   <= '0;
            out_edge_q  <= 1'b0;
        end else if (advance) begin
            s1_valid_q <= accept;
            if (accept) begin
                gx_pos_q <= gx_pos_d;
                gx_neg_q <= gx_neg_d;
                gy_pos_q <= gy_pos_d;
                gy_neg_q <= gy_neg_d;
            end
            s2_q        <= s2_d;
            out_valid_q <= s2_q.valid;
            // Result data only changes when a real result arrives.
            if (s2_q.valid) begin
                out_gx_q   <= s2_q.gx[GRAD_W-1:0];
                out_gy_q   <= s2_q.gy[GRAD_W-1:0];
                out_mag_q  <= mag_d;
                out_edge_q <= (mag_d > threshold);
            end
        end
    end

    // Clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || count_clear) begin
            edge_count_q <= '0;
        end else if (out_valid_q && out_ready && out_edge_q && (edge_count_q != '1)) begin
            edge_count_q <= edge_count_q + CNT_W'(1);
        end
    end

    assign out_valid  = out_valid_q;
    assign out_gx     = out_gx_q;
    assign out_gy     = out_gy_q;
    assign out_mag    = out_mag_q;
    assign out_edge   = out_edge_q;
    assign busy       = s1_valid_q || s2_q.valid || out_valid_q;
    assign edge_count = edge_count_q;

endmodule

// File: tb/tb_sobel_gradient_engine.sv
module tb_sobel_gradient_engine;

    localparam int PIX_W   = 8;
    localparam int CNT_W   = 4;   // narrow counter so saturation is reachable
    localparam int GRAD_W  = PIX_W + 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                     clk = 1'b0;
    logic                     rst, enable, in_valid, out_ready, count_clear;
    logic [9*PIX_W-1:0]       in_pixels;
    logic [GRAD_W-1:0]        threshold;
    logic                     in_ready, out_valid, out_edge, busy;
    logic signed [GRAD_W-1:0] out_gx, out_gy;
    logic [GRAD_W-1:0]        out_mag;
    logic [CNT_W-1:0]         edge_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sobel_gradient_engine #(.PIX_W(PIX_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .in_valid(in_valid), .in_ready(in_ready), .in_pixels(in_pixels),
        .threshold(threshold),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_gx(out_gx), .out_gy(out_gy), .out_mag(out_mag), .out_edge(out_edge),
        .busy(busy), .count_clear(count_clear), .edge_count(edge_count)
    );

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    typedef struct {
        int gx;
        int gy;
        int mag;
        bit e;
    } res_t;

    // Reference: Sobel definitions in plain integer arithmetic.
    function automatic res_t ref_model(input int p[9], input int thr);
        res_t r;
        r.gx  = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
        r.gy  = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
        r.mag = (r.gx < 0 ? -r.gx : r.gx) + (r.gy < 0 ? -r.gy : r.gy);
        r.e   = r.mag > thr;
        return r;
    endfunction

    function automatic logic [9*PIX_W-1:0] pack(input int p[9]);
        logic [9*PIX_W-1:0] v;
        v = '0;
        for (int k = 0; k < 9; k++) v[(8-k)*PIX_W +: PIX_W] = PIX_W'(p[k]);
        return v;
    endfunction

    function automatic logic [9*PIX_W-1:0] rand_window();
        int p[9];
        bit extreme;
        extreme = ($urandom_range(0, 3) == 0);
        for (int k = 0; k < 9; k++)
            p[k] = extreme ? 255 * int'($urandom_range(0, 1)) : int'($urandom_range(0, 255));
        return pack(p);
    endfunction

    // ---------------- scoreboard / monitor ----------------
    res_t exp_q[$];
    int   model_cnt = 0;
    int   delivered = 0;
    bit   hold_prev = 0;
    logic signed [GRAD_W-1:0] hold_gx, hold_gy;
    logic [GRAD_W-1:0]        hold_mag;
    logic                     hold_edge;

    always @(negedge clk) begin
        int   p[9];
        res_t r;
        bit   inc;
        if (rst) begin
            check("in_ready_in_rst", in_ready, 0);
            exp_q.delete();
            model_cnt = 0;
            hold_prev = 0;
        end else begin
            inc = 0;
            check("edge_count", edge_count, model_cnt);
            check("busy", busy, exp_q.size() != 0);
            check("in_ready", in_ready, enable && (!out_valid || out_ready));
            if (hold_prev) begin
                check("hold_valid", out_valid, 1);
                check("hold_gx", out_gx, hold_gx);
                check("hold_gy", out_gy, hold_gy);
                check("hold_mag", out_mag, hold_mag);
                check("hold_edge", out_edge, hold_edge);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", out_valid, 0);
                end else begin
                    r = exp_q.pop_front();
                    delivered++;
                    $display("txn %0d: gx=%0d gy=%0d mag=%0d edge=%0d (ref %0d %0d %0d %0d)",
                             delivered, out_gx, out_gy, out_mag, out_edge, r.gx, r.gy, r.mag, r.e);
                    check("out_gx", out_gx, r.gx);
                    check("out_gy", out_gy, r.gy);
                    check("out_mag", out_mag, r.mag);
                    check("out_edge", out_edge, r.e);
                    inc = r.e;
                end
            end
            if (in_valid && in_ready) begin
                for (int k = 0; k < 9; k++) p[k] = int'(in_pixels[(8-k)*PIX_W +: PIX_W]);
                exp_q.push_back(ref_model(p, int'(threshold)));
            end
            if (count_clear) model_cnt = 0;
            else if (inc && model_cnt < CNT_MAX) model_cnt++;
            hold_prev = out_valid && !out_ready;
            hold_gx   = out_gx;
            hold_gy   = out_gy;
            hold_mag  = out_mag;
            hold_edge = out_edge;
        end
    end

    // Present one window from an idle pipeline; return edges until out_valid.
    task automatic send_and_measure(input int p[9], output int lat);
        @(posedge clk); #1;
        in_pixels = pack(p);
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat, idx, stall, base;
        bit seen, acc;
        int w[9];
        int wins[4][9];

        rst = 1'b1; enable = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        count_clear = 1'b0; in_pixels = '0; threshold = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_gx", out_gx, 0);
        check("rst_out_gy", out_gy, 0);
        check("rst_out_mag", out_mag, 0);
        check("rst_out_edge", out_edge, 0);
        check("rst_busy", busy, 0);
        check("rst_edge_count", edge_count, 0);
        check("rst_in_ready", in_ready, 0);
        rst = 1'b0; enable = 1'b1; out_ready = 1'b1;

        // T1: vertical edge on the right column
        threshold = 100;
        w = '{0, 0, 255, 0, 0, 255, 0, 0, 255};
        send_and_measure(w, lat);
        check("t1_latency", lat, 3);
        check("t1_gx", out_gx, 1020);
        check("t1_gy", out_gy, 0);
        check("t1_mag", out_mag, 1020);
        check("t1_edge", out_edge, 1);
        @(posedge clk); #1;
        check("t1_count", edge_count, 1);

        // T2: ramp, below threshold
        threshold = 400;
        w = '{10, 20, 30, 40, 50, 60, 70, 80, 90};
        send_and_measure(w, lat);
        check("t2_latency", lat, 3);
        check("t2_gx", out_gx, 80);
        check("t2_gy", out_gy, 240);
        check("t2_mag", out_mag, 320);
        check("t2_edge", out_edge, 0);
        @(posedge clk); #1;
        check("t2_count", edge_count, 1);

        // T3: bright top row, negative Gy
        w = '{255, 255, 255, 0, 0, 0, 0, 0, 0};
        send_and_measure(w, lat);
        check("t3_gx", out_gx, 0);
        check("t3_gy", out_gy, -1020);
        check("t3_mag", out_mag, 1020);
        check("t3_edge", out_edge, 1);
        @(posedge clk); #1;
        check("t3_count", edge_count, 2);

        // T4: four back-to-back windows, two-cycle stall on first result
        threshold = 0;
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 9; k++) wins[i][k] = int'($urandom_range(0, 255));
        idx = 0; stall = 0; seen = 0; base = delivered;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (idx >= 4 && !busy) break;
            in_valid = (idx < 4);
            if (idx < 4) in_pixels = pack(wins[idx]);
            if (out_valid && !seen) begin
                seen  = 1;
                stall = 2;
            end
            out_ready = (stall == 0);
            if (stall > 0) stall--;
            @(negedge clk);
            if (!out_ready) check("t4_stall_in_ready", in_ready, 0);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("t4_accepted", idx, 4);
        check("t4_delivered", delivered - base, 4);
        check("t4_idle", busy, 0);

        // T5: reset while two windows are in flight
        in_pixels = rand_window();
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_pixels = rand_window();
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk); #1;
        check("t5_out_valid", out_valid, 0);
        check("t5_busy", busy, 0);
        check("t5_edge_count", edge_count, 0);
        check("t5_in_ready", in_ready, 0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("t5_no_stale", out_valid, 0);
        end

        // T6: enable low drains in-flight work and ignores the offered window
        threshold = 0;
        base      = delivered;
        in_pixels = pack('{0, 0, 255, 0, 0, 255, 0, 0, 255});
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_pixels = pack('{255, 255, 255, 0, 0, 0, 0, 0, 0});
        @(posedge clk); #1;
        enable    = 1'b0;
        in_pixels = rand_window();
        @(negedge clk);
        check("t6_in_ready", in_ready, 0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (!busy) break;
        end
        check("t6_busy_fall", busy, 0);
        check("t6_drained", delivered - base, 2);
        check("t6_count", edge_count, 2);
        in_valid = 1'b0;
        enable   = 1'b1;
        w = '{0, 0, 255, 0, 0, 255, 0, 0, 255};
        send_and_measure(w, lat);
        check("t6_edge_pending", out_edge, 1);
        count_clear = 1'b1;
        @(posedge clk); #1;
        count_clear = 1'b0;
        check("t6_clear_wins", edge_count, 0);

        // Randomized traffic: backpressure, enable gaps, clears, rare resets
        for (int c = 0; c < 800; c++) begin
            @(posedge clk); #1;
            rst         = ($urandom_range(0, 199) == 0);
            enable      = ($urandom_range(0, 9) != 0);
            in_valid    = ($urandom_range(0, 9) < 7);
            out_ready   = ($urandom_range(0, 9) < 7);
            count_clear = ($urandom_range(0, 79) == 0);
            in_pixels   = rand_window();
            if (!busy && $urandom_range(0, 3) == 0) threshold = GRAD_W'($urandom_range(0, 2047));
        end
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; count_clear = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (!busy) break;
        end
        check("drain_idle", busy, 0);
        check("drain_queue", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
